// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// FSM states, opcodes, mux selects and trap causes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    IMMEXEC = 4'd8,
    IMMWB   = 4'd9,
    BRANCH  = 4'd10,
    JUMP    = 4'd11,
    JR      = 4'd12,
    TRAP    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_A      = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGIC = 2'b11;

  localparam logic [1:0] TRAP_NONE = 2'b00;
  localparam logic [1:0] TRAP_ILL  = 2'b01;
  localparam logic [1:0] TRAP_MEM  = 2'b10;

  function automatic logic isLogicImm(
    input logic [5:0] op
  );
    return op inside {OP_ANDI, OP_ORI, OP_XORI};
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle: IR fields and memory
// handshake in, datapath enables and status out.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       PCWrite;
  logic       ExtOp;
  logic       Jr;
  logic       JalEn;
  logic       LuiEn;
  logic [3:0] state;
  logic [1:0] trap;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output IorD, MemRead, MemWrite, IRWrite,
    output RegDst, MemtoReg, RegWrite,
    output ALUSrcA, ALUSrcB, ALUOp, PCSrc,
    output PCWrite, ExtOp, Jr, JalEn, LuiEn,
    output state, trap, instret
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  IorD, MemRead, MemWrite, IRWrite,
    input  RegDst, MemtoReg, RegWrite,
    input  ALUSrcA, ALUSrcB, ALUOp, PCSrc,
    input  PCWrite, ExtOp, Jr, JalEn, LuiEn,
    input  state, trap, instret
  );
endinterface

// File: rtl/mc_mem_wait_timer.sv
// Counts consecutive stalled memory cycles and flags
// the cycle on which the wait limit is reached.
module mc_mem_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic timeout
);
  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam int LASTI = (LIMIT > 0) ? LIMIT - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(LASTI);
  localparam bit EN = (LIMIT != 0);

  logic [CW-1:0] cnt;
  logic waiting;

  assign waiting = active && !ready;
  // ready on the limit cycle suppresses the trap
  assign timeout = EN && waiting && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (EN && waiting && !timeout)
      cnt <= cnt + CW'(1);
    else
      cnt <= '0;
  end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory handshake,
// wait timeout, illegal-opcode trap and retire counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT     = 16,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 32
) (
  input logic clk,
  input logic reset,
  multicycle_control_if.master bus
);
  state_t state;
  state_t stateNxt;
  logic [1:0] trap;
  logic [1:0] trapNxt;
  logic [CNT_W-1:0] instret;
  logic retire;
  logic memWait;
  logic timeout;
  logic [5:0] op;

  assign op = bus.opcode;
  assign memWait = state inside {FETCH, MEMRD, MEMWR};

  mc_mem_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) uTimer (
    .clk    (clk),
    .reset  (reset),
    .active (memWait),
    .ready  (bus.mem_ready),
    .timeout(timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      trap    <= TRAP_NONE;
      instret <= '0;
    end else begin
      state <= stateNxt;
      trap  <= trapNxt;
      if (retire)
        instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    stateNxt = state;
    trapNxt  = trap;
    retire   = 1'b0;
    unique case (state)
      FETCH:
        if (bus.mem_ready) stateNxt = DECODE;
      DECODE:
        unique case (1'b1)
          op == OP_RTYPE && bus.funct == FUNCT_JR:
            stateNxt = JR;
          op == OP_RTYPE && bus.funct != FUNCT_JR:
            stateNxt = EXEC;
          op == OP_LW || op == OP_SW:
            stateNxt = MEMADR;
          op == OP_BEQ || op == OP_BNE:
            stateNxt = BRANCH;
          op == OP_ADDI || op == OP_LUI || isLogicImm(op):
            stateNxt = IMMEXEC;
          op == OP_J || op == OP_JAL:
            stateNxt = JUMP;
          default:
            if (TRAP_ON_ILLEGAL) begin
              stateNxt = TRAP;
              trapNxt  = TRAP_ILL;
            end else begin
              stateNxt = FETCH;
              retire   = 1'b1;
            end
        endcase
      MEMADR:
        stateNxt = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:
        if (bus.mem_ready) stateNxt = MEMWB;
      MEMWR:
        if (bus.mem_ready) begin
          stateNxt = FETCH;
          retire   = 1'b1;
        end
      EXEC:    stateNxt = ALUWB;
      IMMEXEC: stateNxt = IMMWB;
      MEMWB, ALUWB, IMMWB, BRANCH, JUMP, JR: begin
        stateNxt = FETCH;
        retire   = 1'b1;
      end
      TRAP:    stateNxt = TRAP;
      default: stateNxt = FETCH;
    endcase
    if (timeout) begin
      stateNxt = TRAP;
      trapNxt  = TRAP_MEM;
      retire   = 1'b0;
    end
  end

  assign bus.state   = state;
  assign bus.trap    = trap;
  assign bus.instret = instret;

  always_comb begin
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = SRCB_B;
    bus.ALUOp    = ALU_ADD;
    bus.PCSrc    = PC_ALU;
    bus.PCWrite  = 1'b0;
    bus.ExtOp    = 1'b1;
    bus.Jr       = 1'b0;
    bus.JalEn    = 1'b0;
    bus.LuiEn    = 1'b0;
    // datapath stays quiet for the whole reset pulse
    if (!reset) begin
      unique case (state)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = SRCB_4;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        DECODE: bus.ALUSrcB = SRCB_BR;
        MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_IMM;
        end
        MEMRD: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        MEMWB: begin
          bus.MemtoReg = 1'b1;
          bus.RegWrite = 1'b1;
        end
        MEMWR: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
        end
        EXEC: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = ALU_FUNCT;
        end
        ALUWB: begin
          bus.RegDst   = 1'b1;
          bus.RegWrite = 1'b1;
        end
        IMMEXEC, IMMWB: begin
          bus.ALUSrcA  = 1'b1;
          bus.ALUSrcB  = SRCB_IMM;
          bus.RegWrite = (state == IMMWB);
          bus.LuiEn    = (op == OP_LUI);
          if (isLogicImm(op)) begin
            bus.ALUOp = ALU_LOGIC;
            bus.ExtOp = 1'b0;
          end
        end
        BRANCH: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = ALU_SUB;
          bus.PCSrc   = PC_ALUOUT;
          bus.PCWrite = (op == OP_BEQ) ? bus.zero : !bus.zero;
        end
        JUMP: begin
          bus.PCSrc    = PC_JUMP;
          bus.PCWrite  = 1'b1;
          bus.RegWrite = (op == OP_JAL);
          bus.JalEn    = (op == OP_JAL);
        end
        JR: begin
          bus.PCSrc   = PC_A;
          bus.PCWrite = 1'b1;
          bus.Jr      = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed cases plus random
// instruction streams against a per-instruction phase model.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  typedef struct packed {
    logic IorD, MemRead, MemWrite, IRWrite;
    logic RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic PCWrite, ExtOp, Jr, JalEn, LuiEn;
    logic [3:0] state;
    logic [1:0] trap;
  } ctl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetA;
  logic resetB;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic zero;
  logic memReady;

  multicycle_control_if #(.CNT_W(32)) busA ();
  multicycle_control_if #(.CNT_W(3)) busB ();

  assign busA.opcode = opcode;
  assign busA.funct = funct;
  assign busA.zero = zero;
  assign busA.mem_ready = memReady;
  assign busB.opcode = opcode;
  assign busB.funct = funct;
  assign busB.zero = zero;
  assign busB.mem_ready = memReady;

  multicycle_control #(
    .MEM_TIMEOUT(4), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(32)
  ) dutA (.clk(clk), .reset(resetA), .bus(busA));

  multicycle_control #(
    .MEM_TIMEOUT(16), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(3)
  ) dutB (.clk(clk), .reset(resetB), .bus(busB));

  ctl_t obsA;
  ctl_t obsB;
  assign obsA = {busA.IorD, busA.MemRead, busA.MemWrite,
    busA.IRWrite, busA.RegDst, busA.MemtoReg, busA.RegWrite,
    busA.ALUSrcA, busA.ALUSrcB, busA.ALUOp, busA.PCSrc,
    busA.PCWrite, busA.ExtOp, busA.Jr, busA.JalEn,
    busA.LuiEn, busA.state, busA.trap};
  assign obsB = {busB.IorD, busB.MemRead, busB.MemWrite,
    busB.IRWrite, busB.RegDst, busB.MemtoReg, busB.RegWrite,
    busB.ALUSrcA, busB.ALUSrcB, busB.ALUOp, busB.PCSrc,
    busB.PCWrite, busB.ExtOp, busB.Jr, busB.JalEn,
    busB.LuiEn, busB.state, busB.trap};

  int checks = 0;
  int failures = 0;
  int zeroFix = -1;
  int unsigned retA = 0;
  int unsigned retB = 0;
  logic [1:0] expTrap = 2'b00;
  state_t plan[$];
  logic [5:0] legal [12] = '{6'h00, 6'h02, 6'h03, 6'h04,
    6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected control vector for one phase of an instruction
  function automatic ctl_t expCtl(state_t ph, logic [5:0] op,
      logic zr, logic rdy, logic [1:0] tr);
    ctl_t c;
    c = '0;
    c.ExtOp = 1'b1;
    c.state = ph;
    c.trap = tr;
    case (ph)
      FETCH: begin
        c.MemRead = 1; c.ALUSrcB = 2'b01;
        c.IRWrite = rdy; c.PCWrite = rdy;
      end
      DECODE: c.ALUSrcB = 2'b11;
      MEMADR: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
      MEMRD: begin c.MemRead = 1; c.IorD = 1; end
      MEMWB: begin c.MemtoReg = 1; c.RegWrite = 1; end
      MEMWR: begin c.MemWrite = 1; c.IorD = 1; end
      EXEC: begin c.ALUSrcA = 1; c.ALUOp = 2'b10; end
      ALUWB: begin c.RegDst = 1; c.RegWrite = 1; end
      IMMEXEC, IMMWB: begin
        c.ALUSrcA = 1; c.ALUSrcB = 2'b10;
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) begin
          c.ALUOp = 2'b11; c.ExtOp = 0;
        end
        c.LuiEn = (op == 6'h0F);
        c.RegWrite = (ph == IMMWB);
      end
      BRANCH: begin
        c.ALUSrcA = 1; c.ALUOp = 2'b01; c.PCSrc = 2'b01;
        c.PCWrite = (op == 6'h04) ? zr : ~zr;
      end
      JUMP: begin
        c.PCSrc = 2'b10; c.PCWrite = 1;
        c.RegWrite = (op == 6'h03); c.JalEn = (op == 6'h03);
      end
      JR: begin c.PCSrc = 2'b11; c.PCWrite = 1; c.Jr = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic buildPlan(logic [5:0] op, logic [5:0] fn,
                           bit trapIll);
    plan.delete();
    plan.push_back(FETCH);
    plan.push_back(DECODE);
    case (op)
      6'h00: if (fn == 6'h08) plan.push_back(JR);
             else begin plan.push_back(EXEC); plan.push_back(ALUWB); end
      6'h23: begin plan.push_back(MEMADR); plan.push_back(MEMRD);
                   plan.push_back(MEMWB); end
      6'h2B: begin plan.push_back(MEMADR); plan.push_back(MEMWR); end
      6'h04, 6'h05: plan.push_back(BRANCH);
      6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        plan.push_back(IMMEXEC); plan.push_back(IMMWB);
      end
      6'h02, 6'h03: plan.push_back(JUMP);
      default: if (trapIll) plan.push_back(TRAP);
    endcase
  endtask

  task automatic step(bit b, string tag, ctl_t exp);
    @(negedge clk);
    chk(tag, b ? obsB : obsA, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic chkRet(bit b);
    if (b) chk("instretB", 64'(busB.instret), 64'(retB % 8));
    else   chk("instretA", 64'(busA.instret), 64'(retA));
  endtask

  task automatic runInstr(bit b, logic [5:0] op,
                          logic [5:0] fn, int waitFix);
    state_t ph;
    int waits;
    logic rdy;
    bit isMem;
    buildPlan(op, fn, !b);
    chkRet(b);
    foreach (plan[i]) begin
      ph = plan[i];
      isMem = (ph == FETCH || ph == MEMRD || ph == MEMWR);
      waits = 0;
      if (isMem)
        waits = (waitFix >= 0) ? waitFix
              : int'($urandom_range(0, b ? 5 : 3));
      if (ph == TRAP) begin
        waits = 3;
        expTrap = TRAP_ILL;
      end
      for (int k = 0; k <= waits; k++) begin
        opcode = (ph == FETCH) ? 6'($urandom) : op;
        funct = (ph == FETCH) ? 6'($urandom) : fn;
        zero = (zeroFix >= 0) ? zeroFix[0] : 1'($urandom);
        rdy = isMem ? (k == waits) : 1'($urandom);
        memReady = rdy;
        step(b, ph.name(), expCtl(ph, op, zero, rdy, expTrap));
      end
    end
    if (plan[plan.size()-1] != TRAP) begin
      if (b) retB++; else retA++;
    end
  endtask

  task automatic doReset(bit b);
    ctl_t rc;
    rc = '0;
    rc.ExtOp = 1'b1;
    memReady = 1'b1;
    if (b) resetB = 1'b1; else resetA = 1'b1;
    #1;
    chk("rstAsync", b ? obsB : obsA, rc);
    @(negedge clk);
    chk("rstHold", b ? obsB : obsA, rc);
    if (b) retB = 0; else retA = 0;
    chkRet(b);
    @(posedge clk);
    #1;
    if (b) resetB = 1'b0; else resetA = 1'b0;
    expTrap = TRAP_NONE;
  endtask

  task automatic randInstr(bit b, bit allowIll);
    logic [5:0] op;
    logic [5:0] fn;
    op = legal[$urandom_range(0, 11)];
    if (allowIll && $urandom_range(0, 3) == 0) op = 6'($urandom);
    fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
    runInstr(b, op, fn, -1);
  endtask

  initial begin
    ctl_t rc;
    rc = '0;
    rc.ExtOp = 1'b1;
    resetA = 1'b1;
    resetB = 1'b1;
    opcode = '0;
    funct = '0;
    zero = 1'b0;
    memReady = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstInitA", obsA, rc);
    chk("rstInitB", obsB, rc);
    @(posedge clk);
    #1;
    resetA = 1'b0;

    runInstr(0, 6'h00, 6'h20, 0);
    runInstr(0, 6'h23, 6'h00, 0);
    zeroFix = 1;
    runInstr(0, 6'h04, 6'h00, 0);
    runInstr(0, 6'h05, 6'h00, 0);
    zeroFix = 0;
    runInstr(0, 6'h05, 6'h00, 0);
    zeroFix = -1;
    runInstr(0, 6'h23, 6'h00, 3);
    runInstr(0, 6'h00, 6'h08, 1);
    runInstr(0, 6'h0F, 6'h00, 0);
    for (int i = 0; i < 40; i++) randInstr(0, 1'b0);

    chkRet(0);
    opcode = 6'h23;
    memReady = 1'b0;
    repeat (4) step(0, "fetchWait",
      expCtl(FETCH, 6'h23, zero, 1'b0, TRAP_NONE));
    repeat (3) begin
      memReady = 1'($urandom);
      step(0, "memTrap", expCtl(TRAP, 6'h23, zero, 1'b0, TRAP_MEM));
    end
    doReset(0);

    runInstr(0, 6'h3F, 6'h00, 0);
    doReset(0);
    runInstr(0, 6'h2B, 6'h00, 2);
    resetA = 1'b1;

    resetB = 1'b0;
    runInstr(1, 6'h2B, 6'h00, 5);
    runInstr(1, 6'h3F, 6'h00, 0);
    runInstr(1, 6'h03, 6'h00, 0);
    runInstr(1, 6'h0D, 6'h00, 0);
    for (int i = 0; i < 30; i++) randInstr(1, 1'b1);
    chkRet(1);
    @(negedge clk);
    chk("rstHeldA", obsA, rc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
